// File: rtl/baud_gen.sv
// UART oversample/mid-bit/bit tick generator with runtime integer + fractional divisor.
// Optional fractional accumulator is compiled in when BAUD_GEN_FRAC_EN is defined.
module baud_gen #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic [OSR_W-1:0]  osr,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    logic [DIV_W:0]   cnt;
    logic [DIV_W:0]   limit;
    logic [OSR_W-1:0] os_cnt;
    logic             carry_q;
    logic             os_event;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, acc} + {1'b0, div_frac};

    // Carry-out of the accumulator stretches the following period by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (sync) begin
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (enable && os_event) begin
            {carry_q, acc} <= frac_sum;
        end
    end
`else
    logic unused_div_frac;

    assign carry_q         = 1'b0;
    assign unused_div_frac = ^div_frac;
`endif

    // Extra bit keeps all-ones div_int plus carry from wrapping.
    assign limit    = {1'b0, div_int} + {{DIV_W{1'b0}}, carry_q};
    assign os_event = (cnt >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else if (sync) begin
            cnt      <= '0;
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else if (!enable) begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else if (os_event) begin
            cnt      <= '0;
            os_tick  <= 1'b1;
            mid_tick <= (os_cnt == (osr >> 1));
            // >= so that lowering osr mid-bit still terminates the bit.
            if (os_cnt >= osr) begin
                os_cnt   <= '0;
                bit_tick <= 1'b1;
            end else begin
                os_cnt   <= os_cnt + {{(OSR_W-1){1'b0}}, 1'b1};
                bit_tick <= 1'b0;
            end
        end else begin
            cnt      <= cnt + {{DIV_W{1'b0}}, 1'b1};
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen; expectations adapt to BAUD_GEN_FRAC_EN.
module tb_baud_gen;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sync;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic [4:0]  osr;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;

    int n_checks;
    int n_fail;

    baud_gen #(.DIV_W(16), .FRAC_W(4), .OSR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sync     (sync),
        .div_int  (div_int),
        .div_frac (div_frac),
        .osr      (osr),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Counts edges until the selected strobe is seen (0=os,1=mid,2=bit); -1 if the bound expires.
    task automatic wait_ev(input int sel, input int max_edges, output int n);
        bit seen;
        seen = 1'b0;
        n = -1;
        for (int i = 1; i <= max_edges && !seen; i++) begin
            @(negedge clk);
            if ((sel == 0 && os_tick) || (sel == 1 && mid_tick) || (sel == 2 && bit_tick)) begin
                seen = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic do_sync(input string tag);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check(tag, {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
    endtask

    task automatic count_os(input int edges, output int cnt_os);
        cnt_os = 0;
        for (int i = 0; i < edges; i++) begin
            @(negedge clk);
            cnt_os += int'(os_tick);
        end
    endtask

    initial begin
        logic [31:0] os_v, mid_v, bit_v;
        int n, n2, total, cnt_os;
        int exp_gap [5];

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        sync     = 1'b0;
        div_int  = '0;
        div_frac = '0;
        osr      = '0;

        #2;
        check("reset_outputs", {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // div 4, 4x oversample: os every 4 edges, mid on os_cnt==1, bit every 16 edges
        div_int = 16'd3;
        osr     = 5'd3;
        enable  = 1'b1;
        os_v = '0; mid_v = '0; bit_v = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            os_v[i]  = os_tick;
            mid_v[i] = mid_tick;
            bit_v[i] = bit_tick;
        end
        check("div4_os_pattern", os_v, 32'h8888_8888);
        check("div4_mid_pattern", mid_v, 32'h0080_0080);
        check("div4_bit_pattern", bit_v, 32'h8000_8000);

        // Fractional 9 + 8/16: periods 10,10,11,10,11; 16th tick visible in cycle 168
        div_int  = 16'd9;
        div_frac = 4'd8;
        osr      = 5'd15;
        do_sync("frac_sync_clear");
`ifdef BAUD_GEN_FRAC_EN
        exp_gap = '{10, 10, 11, 10, 11};
`else
        exp_gap = '{10, 10, 10, 10, 10};
`endif
        total = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ev(0, 40, n);
            check($sformatf("frac_period_%0d", k + 1), n, exp_gap[k]);
            total += n;
        end
        for (int k = 5; k < 16; k++) begin
            wait_ev(0, 40, n);
            total += (n < 0) ? 1000 : n;
        end
`ifdef BAUD_GEN_FRAC_EN
        check("frac_16_ticks_cycle", total + 1, 168);
`else
        check("frac_16_ticks_cycle", total + 1, 161);
`endif

        // div 1, osr 0: every strobe every cycle while enabled
        div_int  = 16'd0;
        div_frac = 4'd0;
        osr      = 5'd0;
        do_sync("fast_sync_clear");
        os_v = '0; mid_v = '0; bit_v = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            os_v[i]  = os_tick;
            mid_v[i] = mid_tick;
            bit_v[i] = bit_tick;
        end
        check("fast_os_every_cycle", os_v, 32'h0000_00ff);
        check("fast_mid_every_cycle", mid_v, 32'h0000_00ff);
        check("fast_bit_every_cycle", bit_v, 32'h0000_00ff);
        enable = 1'b0;
        @(negedge clk);
        check("fast_disable_quiet", {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);

        // Async reset between edges while bit_tick is high
        enable = 1'b1;
        @(negedge clk);
        check("pre_reset_bit_tick", {31'd0, bit_tick}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_clears", {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lower div_int below a running count: event on next edge, then 6-cycle period
        div_int = 16'd100;
        osr     = 5'd15;
        count_os(50, cnt_os);
        check("div100_no_tick_50", cnt_os, 0);
        div_int = 16'd5;
        wait_ev(0, 5, n);
        check("div_lowered_first", n, 1);
        wait_ev(0, 20, n);
        check("div_lowered_period", n, 6);

        // Enable gap with cnt=3: 3 edges before, 5 after, 8 enabled edges in total
        div_int = 16'd7;
        do_sync("gap_sync_clear");
        count_os(3, cnt_os);
        check("gap_pre_quiet", cnt_os, 0);
        enable = 1'b0;
        count_os(5, cnt_os);
        check("gap_disabled_quiet", cnt_os, 0);
        enable = 1'b1;
        wait_ev(0, 20, n);
        check("gap_resume_edges", n, 5);

        // sync mid-bit: first os after 8 edges, first mid on the 8th os (edge 64)
        count_os(40, cnt_os);
        do_sync("mid_sync_clear");
        wait_ev(0, 50, n);
        check("sync_first_os", n, 8);
        wait_ev(1, 100, n2);
        check("sync_first_mid", (n2 < 0) ? -1 : n + n2, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
